uart_reg_bank: RTL
==================

# uart_reg_bank

UART register bank and byte FIFOs sitting directly downstream of the APB slave front-end. It decodes the front-end's write/read strobes (waddr/wdata/wr_en, raddr/rd_en) against the UART register map. It returns rdata with single-cycle acks and address errors. It buffers transmit and receive bytes between the CPU and the UART TX/RX shift engines, and drives configuration and interrupt outputs to those engines.

## Interface
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of 2, range 2..16
- BAUD_RST, 16'h0036, reset value of baud divisor
- pclk  in  1  clock
- prst_n  in  1  reset, asynchronous, active-low
- waddr  in  12  write byte address, qualified by wr_en
- wdata  in  32  write data, qualified by wr_en
- wr_en  in  1  write strobe, one cycle per access
- raddr  in  12  read byte address, valid in same cycle as rd_en
- rd_en  in  1  read strobe, one cycle per access
- rdata  out  32  read data, valid while rack=1, else 0
- wack  out  1  write acknowledge
- rack  out  1  read acknowledge
- waddrerr  out  1  write error, only with wack
- raddrerr  out  1  read error, only with rack
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX byte available to transmitter
- tx_ready  in  1  transmitter accepts byte
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- baud_div  out  16  baud divisor
- data_bits  out  2  00=5 … 11=8 bits
- parity_en, parity_odd, stop2  out  1 each  frame config
- irq  out  1  interrupt, registered

## Operation
- Register map (word-aligned byte addresses):
  - 0x000 CTRL RW: [0] tx_en, [1] rx_en, [3:2] data_bits, [4] parity_en, [5] parity_odd, [6] stop2. Reset 0x0000_000F.
  - 0x004 BAUD RW: [15:0]. Reset BAUD_RST.
  - 0x008 TXDATA WO: write pushes wdata[7:0]. Read returns 0, no error.
  - 0x00C RXDATA RO: read pops the head and returns {24'b0, byte}. When empty, returns 0 and no pop. Write gives waddrerr.
  - 0x010 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] overrun (sticky), [12:8] tx_count, [20:16] rx_count. Write with wdata[4]=1 clears overrun; other bits are ignored. Reset 0x0000_000A.
  - 0x014 IER RW: [0] tx_empty, [1] rx_not_empty, [2] overrun enables. Reset 0.
- Unused bits read 0. Writes to RW registers ignore unused bits.
- Error cases: address > 0x014 or addr[1:0]≠0 gives the error for that direction. The access is ignored and reads return 0.
- TXDATA write while TX full gives waddrerr=1. The byte is dropped.
- tx_valid = tx_en & !tx_empty. The FIFO pops on tx_valid & tx_ready.
- RX push on rx_valid & rx_en. If the FIFO is full, the byte is dropped and overrun is set.
- RX full with a pop and push in the same cycle: both occur, no overrun.
- TX full with a push and pop in the same cycle: push accepted, no error.
- irq next-state = (IER[0]&tx_empty) | (IER[1]&!rx_empty) | (IER[2]&overrun).
- Counters use $clog2(FIFO_DEPTH)+1 bits and are zero-extended into STATUS fields. Pointers wrap modulo FIFO_DEPTH.

## Timing
- wack = wr_en and rack = rd_en, combinational in the same cycle. waddrerr, raddrerr and rdata are combinational in that cycle.
- Register and FIFO updates from a write take effect at the pclk edge that ends the wr_en cycle. A read of any register in the next cycle returns the new value.
- RX pop occurs at the edge ending the rd_en cycle. Each rd_en cycle addressed to RXDATA pops once.
- tx_data/tx_valid update one cycle after a push into an empty TX FIFO.
- rx_valid to rx_count increment: 1 cycle.
- irq lags its condition by 1 cycle.
- Simultaneous wr_en and rd_en are legal and independent. STATUS read in the same cycle as a TXDATA push shows the pre-push value.
- Reset, including mid-transfer:
  - all registers return to reset values, FIFOs empty, overrun 0, irq 0, tx_valid 0.
  - wack, rack, waddrerr, raddrerr and rdata are 0 because strobes are low.

## Test plan
- Reset, then read each register → CTRL 0x0F, BAUD 0x0036, STATUS 0x0A, IER 0, RXDATA 0 with rack=1 and raddrerr=0.
- Write BAUD 0x1234_00A5 then read → 0x0000_00A5. Write CTRL 0xFFFF_FFFF then read → 0x7F, data_bits=11, stop2=1.
- Push 16 bytes 0x00..0x0F with tx_ready=0 → tx_full=1, tx_count=16. 17th write gives waddrerr=1. Then tx_ready=1 drains 0x00..0x0F in order, 1 per cycle, and tx_empty=1 after.
- Pulse rx_valid 17 times with 0xA0..0xB0 → rx_full; 0xB0 is dropped and overrun=1. With IER=4, irq=1 the next cycle. Reading RXDATA 16 times returns 0xA0..0xAF. A STATUS write of 0x10 clears overrun, and irq falls 1 cycle later.
- Address errors:
  - read 0x018 → raddrerr=1, rdata 0.
  - write 0x002 → waddrerr=1, no state change.
  - write RXDATA → waddrerr=1.
- With RX full, a same-cycle rx_valid and RXDATA read → head returned, new byte stored, rx_count stays 16, overrun stays 0. Asserting prst_n=0 mid-stream → all FIFOs empty and outputs at reset values.

Source files
------------

// File: rtl/uart_reg_bank.sv
// ----------------------------------------------------------------------------
// uart_reg_bank
//
// UART register bank and byte FIFOs behind the APB slave front-end. The block
// decodes single-cycle write and read strobes against the UART register map.
// It returns read data, acknowledges and address errors in the same cycle. It
// holds TX and RX byte FIFOs between the CPU and the shift engines, and drives
// the frame configuration and a registered interrupt.
//
// Register map (byte addresses, word aligned):
//   0x000 CTRL    RW  [0] tx_en [1] rx_en [3:2] data_bits [4] parity_en
//                     [5] parity_odd [6] stop2               reset 0x0000_000F
//   0x004 BAUD    RW  [15:0] divisor                           reset BAUD_RST
//   0x008 TXDATA  WO  write pushes wdata[7:0]; reads return 0
//   0x00C RXDATA  RO  read pops head byte (0 when empty); writes are errors
//   0x010 STATUS      [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                     [4] overrun (sticky, write 1 to clear) [12:8] tx_count
//                     [20:16] rx_count                       reset 0x0000_000A
//   0x014 IER     RW  [0] tx_empty [1] rx_not_empty [2] overrun  reset 0
//
// Ports:
//   pclk, prst_n            clock, asynchronous active-low reset
//   waddr/wdata/wr_en       write access from the front-end
//   raddr/rd_en             read access from the front-end
//   rdata, wack, rack       same-cycle read data and acknowledges
//   waddrerr, raddrerr      same-cycle access errors
//   tx_data/tx_valid/tx_ready   byte stream to the transmitter
//   rx_data/rx_valid        byte stream from the receiver
//   baud_div, data_bits, parity_en, parity_odd, stop2   frame configuration
//   irq                     registered interrupt request
// ----------------------------------------------------------------------------
module uart_reg_bank #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RST   = 16'h0036
) (
    input  logic        pclk,
    input  logic        prst_n,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic [11:0] raddr,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        wack,
    output logic        rack,
    output logic        waddrerr,
    output logic        raddrerr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_div,
    output logic [1:0]  data_bits,
    output logic        parity_en,
    output logic        parity_odd,
    output logic        stop2,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [11:0] ADDR_CTRL   = 12'h000;
    localparam logic [11:0] ADDR_BAUD   = 12'h004;
    localparam logic [11:0] ADDR_TXDATA = 12'h008;
    localparam logic [11:0] ADDR_RXDATA = 12'h00C;
    localparam logic [11:0] ADDR_STATUS = 12'h010;
    localparam logic [11:0] ADDR_IER    = 12'h014;

    localparam logic [6:0]  CTRL_RST    = 7'h0F;

    // ------------------------------------------------------------------
    // Configuration and status state
    // ------------------------------------------------------------------
    logic [6:0]  ctrl;
    logic [15:0] baud;
    logic [2:0]  ier;
    logic        overrun;

    logic        tx_en;
    logic        rx_en;

    assign tx_en      = ctrl[0];
    assign rx_en      = ctrl[1];
    assign data_bits  = ctrl[3:2];
    assign parity_en  = ctrl[4];
    assign parity_odd = ctrl[5];
    assign stop2      = ctrl[6];
    assign baud_div   = baud;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr;
    logic [PW-1:0] tx_rd_ptr;
    logic [CW-1:0] tx_count;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_ptr;
    logic [PW-1:0] rx_rd_ptr;
    logic [CW-1:0] rx_count;

    logic tx_full, tx_empty, rx_full, rx_empty;

    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_count == '0);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_ok, r_ok;
    logic wr_ctrl, wr_baud, wr_txdata, wr_rxdata, wr_status, wr_ier;
    logic rd_rxdata;

    // Legal addresses are word aligned and no higher than the last register.
    assign w_ok = (waddr[1:0] == 2'b00) && (waddr <= ADDR_IER);
    assign r_ok = (raddr[1:0] == 2'b00) && (raddr <= ADDR_IER);

    assign wr_ctrl   = wr_en && (waddr == ADDR_CTRL);
    assign wr_baud   = wr_en && (waddr == ADDR_BAUD);
    assign wr_txdata = wr_en && (waddr == ADDR_TXDATA);
    assign wr_rxdata = wr_en && (waddr == ADDR_RXDATA);
    assign wr_status = wr_en && (waddr == ADDR_STATUS);
    assign wr_ier    = wr_en && (waddr == ADDR_IER);

    assign rd_rxdata = rd_en && (raddr == ADDR_RXDATA);

    // ------------------------------------------------------------------
    // FIFO handshakes
    // ------------------------------------------------------------------
    logic tx_push, tx_pop, tx_reject;
    logic rx_push_req, rx_push, rx_pop, rx_drop;

    assign tx_valid = tx_en && !tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign tx_pop   = tx_valid && tx_ready;

    // A full TX FIFO still takes a byte when the transmitter frees a slot
    // on the same edge.
    assign tx_reject = wr_txdata && tx_full && !tx_pop;
    assign tx_push   = wr_txdata && !tx_reject;

    assign rx_pop      = rd_rxdata && !rx_empty;
    assign rx_push_req = rx_valid && rx_en;
    // Likewise a full RX FIFO accepts a byte when the CPU pops on the same edge.
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_drop     = rx_push_req && rx_full && !rx_pop;

    // ------------------------------------------------------------------
    // Same-cycle response
    // ------------------------------------------------------------------
    assign wack     = wr_en;
    assign rack     = rd_en;
    assign waddrerr = wr_en && (!w_ok || wr_rxdata || tx_reject);
    assign raddrerr = rd_en && !r_ok;

    logic [4:0]  tx_cnt5;
    logic [4:0]  rx_cnt5;
    logic [31:0] status_word;

    assign tx_cnt5 = 5'(tx_count);
    assign rx_cnt5 = 5'(rx_count);

    assign status_word = {11'h000, rx_cnt5, 3'b000, tx_cnt5, 3'b000,
                          overrun, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata = 32'h0000_0000;
        if (rd_en) begin
            case (raddr)
                ADDR_CTRL:   rdata = {25'h0, ctrl};
                ADDR_BAUD:   rdata = {16'h0, baud};
                ADDR_RXDATA: rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
                ADDR_STATUS: rdata = status_word;
                ADDR_IER:    rdata = {29'h0, ier};
                // TXDATA and every illegal address read as zero.
                default:     rdata = 32'h0000_0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PW'(1);
            end
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers, overrun flag and interrupt
    // ------------------------------------------------------------------
    logic irq_next;

    assign irq_next = (ier[0] && tx_empty) ||
                      (ier[1] && !rx_empty) ||
                      (ier[2] && overrun);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ctrl    <= CTRL_RST;
            baud    <= BAUD_RST;
            ier     <= 3'b000;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata[6:0];
            end
            if (wr_baud) begin
                baud <= wdata[15:0];
            end
            if (wr_ier) begin
                ier <= wdata[2:0];
            end
            // A byte lost on the same edge as a clear request keeps the flag
            // set so the loss is never hidden from software.
            if (rx_drop) begin
                overrun <= 1'b1;
            end else if (wr_status && wdata[4]) begin
                overrun <= 1'b0;
            end
            irq <= irq_next;
        end
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:16];

endmodule
